sprite_renderer: RTL and testbench

SPRITE_RENDERER -- requirements
Module: sprite_renderer

---
 rtl/sprite_pkg.sv | 58 +++++
 rtl/sprite_rom.sv | 65 ++++++
 rtl/sprite_renderer.sv | 239 +++++++++++++++++++++++
 tb/tb_sprite_renderer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite renderer.
//   Colour constants (RGB444), sprite/bullet dimensions, the player reset
//   position, sprite identifiers, the bullet record, the update-slot state
//   encoding, and small helpers for per-row alien colour and span tests.
package sprite_pkg;

  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] RED   = 12'hF00;
  localparam logic [11:0] GREEN = 12'h0F0;
  localparam logic [11:0] BLACK = 12'h000;

  localparam logic [11:0] ROW_MAGENTA = 12'hF0F;
  localparam logic [11:0] ROW_CYAN    = 12'h0FF;
  localparam logic [11:0] ROW_YELLOW  = 12'hFF0;
  localparam logic [11:0] ROW_BLUE    = 12'h08F;
  localparam logic [11:0] ROW_ORANGE  = 12'hF80;

  localparam int unsigned SPR_W = 16;
  localparam int unsigned SPR_H = 8;
  localparam int unsigned BUL_W = 2;
  localparam int unsigned BUL_H = 6;

  localparam logic [9:0] DEFAULT_PLAYER_X = 10'd312;

  typedef enum logic [1:0] {
    SPR_ALIEN_A = 2'd0,
    SPR_ALIEN_B = 2'd1,
    SPR_PLAYER  = 2'd2
  } sprite_id_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
  } bullet_t;

  // Alien rows cycle through five colours for grids taller than five rows.
  function automatic logic [11:0] row_colour(input int unsigned row);
    case (row % 5)
      0:       return ROW_MAGENTA;
      1:       return ROW_CYAN;
      2:       return ROW_YELLOW;
      3:       return ROW_BLUE;
      default: return ROW_ORANGE;
    endcase
  endfunction

  // d is an 11-bit two's-complement difference; a negative value is a miss.
  function automatic logic in_span(input logic [10:0] d, input logic [10:0] span);
    return !d[10] && (d < span);
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// sprite_rom: combinational 16x8 bitmap lookup.
//   sprite_id : which bitmap (alien frame A, alien frame B, player)
//   row       : bitmap row 0..7
//   col       : bitmap column 0..15, column 0 is the leftmost pixel
//   pixel     : 1 where the bitmap is lit
module sprite_rom
  import sprite_pkg::*;
(
  input  sprite_id_t sprite_id,
  input  logic [2:0] row,
  input  logic [3:0] col,
  output logic       pixel
);

  logic [15:0] line;

  always_comb begin
    line = '0;
    case (sprite_id)
      SPR_ALIEN_A: begin
        case (row)
          3'd0: line = 16'h0810;
          3'd1: line = 16'h0420;
          3'd2: line = 16'h0FF0;
          3'd3: line = 16'h1BD8;
          3'd4: line = 16'h3FFC;
          3'd5: line = 16'h2FF4;
          3'd6: line = 16'h2814;
          3'd7: line = 16'h0660;
          default: line = '0;
        endcase
      end
      SPR_ALIEN_B: begin
        case (row)
          3'd0: line = 16'h0810;
          3'd1: line = 16'h2424;
          3'd2: line = 16'h2FF4;
          3'd3: line = 16'h3BDC;
          3'd4: line = 16'h3FFC;
          3'd5: line = 16'h1FF8;
          3'd6: line = 16'h0810;
          3'd7: line = 16'h1008;
          default: line = '0;
        endcase
      end
      SPR_PLAYER: begin
        case (row)
          3'd0: line = 16'h0180;
          3'd1: line = 16'h03C0;
          3'd2: line = 16'h03C0;
          3'd3: line = 16'h3FFC;
          3'd4: line = 16'h7FFE;
          3'd5: line = 16'hFFFF;
          3'd6: line = 16'hFFFF;
          3'd7: line = 16'hFFFF;
          default: line = '0;
        endcase
      end
      default: line = '0;
    endcase
    // MSB holds the leftmost column.
    pixel = line[4'd15 - col];
  end

endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: per-pixel colour for an alien grid, a player ship and two
// bullets, driven by the VGA timing stage on the pixel clock.
//   clk, reset            : pixel clock, asynchronous active-high reset
//   h_addr, v_addr        : visible pixel coordinate
//   frame_sync            : one-cycle pulse per frame in vertical blanking
//   upd_valid/upd_ready   : update handshake; ready means the pending slot is empty
//   upd_player_x, upd_grid_x, upd_grid_y, upd_alive,
//   upd_pbul_*, upd_abul_* : scene update, applied at the next frame_sync
//   pixel_data            : registered RGB444, one cycle after h_addr/v_addr
// Build option: define SPRITE_ANIM_EN to add a 6-bit frame counter whose
// bit 5 alternates the alien bitmap between frame A and frame B.
module sprite_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned ALIEN_COLS = 8,
  parameter int unsigned ALIEN_ROWS = 5,
  parameter int unsigned CELL_W     = 24,
  parameter int unsigned CELL_H     = 16,
  parameter int unsigned PLAYER_Y   = 440
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [9:0]                       h_addr,
  input  logic [9:0]                       v_addr,
  input  logic                             frame_sync,
  input  logic                             upd_valid,
  output logic                             upd_ready,
  input  logic [9:0]                       upd_player_x,
  input  logic [9:0]                       upd_grid_x,
  input  logic [9:0]                       upd_grid_y,
  input  logic [ALIEN_ROWS*ALIEN_COLS-1:0] upd_alive,
  input  logic [9:0]                       upd_pbul_x,
  input  logic [9:0]                       upd_pbul_y,
  input  logic [9:0]                       upd_abul_x,
  input  logic [9:0]                       upd_abul_y,
  input  logic                             upd_pbul_en,
  input  logic                             upd_abul_en,
  output logic [11:0]                      pixel_data
);

  localparam int unsigned N_ALIENS = ALIEN_ROWS * ALIEN_COLS;
  localparam int unsigned GRID_W   = ALIEN_COLS * CELL_W;
  localparam int unsigned GRID_H   = ALIEN_ROWS * CELL_H;
  localparam int unsigned COL_W    = (ALIEN_COLS > 1) ? $clog2(ALIEN_COLS) : 1;
  localparam int unsigned ROW_W    = (ALIEN_ROWS > 1) ? $clog2(ALIEN_ROWS) : 1;

  // ---------------------------------------------------------------------------
  // Update slot: one pending scene, promoted to active on frame_sync.
  // ---------------------------------------------------------------------------
  slot_state_t slot_state, slot_next;
  logic        load_pend, commit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_state <= SLOT_EMPTY;
    else       slot_state <= slot_next;
  end

  always_comb begin
    slot_next = slot_state;
    load_pend = 1'b0;
    commit    = 1'b0;
    upd_ready = 1'b0;
    case (slot_state)
      SLOT_EMPTY: begin
        upd_ready = 1'b1;
        // A transfer coinciding with frame_sync only fills the slot; it
        // waits for the next frame_sync to become active.
        if (upd_valid) begin
          load_pend = 1'b1;
          slot_next = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (frame_sync) begin
          commit    = 1'b1;
          slot_next = SLOT_EMPTY;
        end
      end
      default: slot_next = SLOT_EMPTY;
    endcase
  end

  logic [9:0]          pend_player_x, pend_grid_x, pend_grid_y;
  logic [N_ALIENS-1:0] pend_alive;
  bullet_t             pend_pbul, pend_abul;

  logic [9:0]          act_player_x, act_grid_x, act_grid_y;
  logic [N_ALIENS-1:0] act_alive;
  bullet_t             act_pbul, act_abul;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_player_x <= DEFAULT_PLAYER_X;
      pend_grid_x   <= '0;
      pend_grid_y   <= '0;
      pend_alive    <= '0;
      pend_pbul     <= '0;
      pend_abul     <= '0;
    end else if (load_pend) begin
      pend_player_x <= upd_player_x;
      pend_grid_x   <= upd_grid_x;
      pend_grid_y   <= upd_grid_y;
      pend_alive    <= upd_alive;
      pend_pbul     <= '{en: upd_pbul_en, x: upd_pbul_x, y: upd_pbul_y};
      pend_abul     <= '{en: upd_abul_en, x: upd_abul_x, y: upd_abul_y};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_player_x <= DEFAULT_PLAYER_X;
      act_grid_x   <= '0;
      act_grid_y   <= '0;
      act_alive    <= '0;
      act_pbul     <= '0;
      act_abul     <= '0;
    end else if (commit) begin
      act_player_x <= pend_player_x;
      act_grid_x   <= pend_grid_x;
      act_grid_y   <= pend_grid_y;
      act_alive    <= pend_alive;
      act_pbul     <= pend_pbul;
      act_abul     <= pend_abul;
    end
  end

  // ---------------------------------------------------------------------------
  // Animation frame select
  // ---------------------------------------------------------------------------
  sprite_id_t alien_id;

`ifdef SPRITE_ANIM_EN
  logic [5:0] frame_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           frame_cnt <= '0;
    else if (frame_sync) frame_cnt <= frame_cnt + 6'd1;
  end

  assign alien_id = frame_cnt[5] ? SPR_ALIEN_B : SPR_ALIEN_A;
`else
  assign alien_id = SPR_ALIEN_A;
`endif

  // ---------------------------------------------------------------------------
  // Hit tests on 11-bit two's-complement offsets (bit 10 set = left/above).
  // ---------------------------------------------------------------------------
  logic [10:0] pdx, pdy, gdx, gdy, pbdx, pbdy, abdx, abdy;

  assign pdx  = {1'b0, h_addr} - {1'b0, act_player_x};
  assign pdy  = {1'b0, v_addr} - 11'(PLAYER_Y);
  assign gdx  = {1'b0, h_addr} - {1'b0, act_grid_x};
  assign gdy  = {1'b0, v_addr} - {1'b0, act_grid_y};
  assign pbdx = {1'b0, h_addr} - {1'b0, act_pbul.x};
  assign pbdy = {1'b0, v_addr} - {1'b0, act_pbul.y};
  assign abdx = {1'b0, h_addr} - {1'b0, act_abul.x};
  assign abdy = {1'b0, v_addr} - {1'b0, act_abul.y};

  logic pbul_hit, abul_hit, player_hit, alien_hit;
  logic player_bit, alien_bit;

  assign pbul_hit = act_pbul.en && in_span(pbdx, 11'(BUL_W)) && in_span(pbdy, 11'(BUL_H));
  assign abul_hit = act_abul.en && in_span(abdx, 11'(BUL_W)) && in_span(abdy, 11'(BUL_H));

  sprite_rom u_player_rom (
    .sprite_id (SPR_PLAYER),
    .row       (pdy[2:0]),
    .col       (pdx[3:0]),
    .pixel     (player_bit)
  );

  assign player_hit = in_span(pdx, 11'(SPR_W)) && in_span(pdy, 11'(SPR_H)) && player_bit;

  // Cell index by compare/subtract against each constant cell boundary: the
  // last boundary not exceeded is the cell, the remainder is the local offset.
  logic [COL_W-1:0] cell_col;
  logic [ROW_W-1:0] cell_row;
  logic [10:0]      loc_x, loc_y;
  logic             alive_bit;
  logic [11:0]      alien_colour;

  always_comb begin
    cell_col     = '0;
    cell_row     = '0;
    loc_x        = gdx;
    loc_y        = gdy;
    alive_bit    = 1'b0;
    alien_colour = BLACK;
    for (int unsigned c = 0; c < ALIEN_COLS; c++) begin
      if (gdx >= 11'(c * CELL_W)) begin
        cell_col = COL_W'(c);
        loc_x    = gdx - 11'(c * CELL_W);
      end
    end
    for (int unsigned r = 0; r < ALIEN_ROWS; r++) begin
      if (gdy >= 11'(r * CELL_H)) begin
        cell_row = ROW_W'(r);
        loc_y    = gdy - 11'(r * CELL_H);
      end
    end
    for (int unsigned r = 0; r < ALIEN_ROWS; r++) begin
      if (cell_row == ROW_W'(r)) alien_colour = row_colour(r);
      for (int unsigned c = 0; c < ALIEN_COLS; c++) begin
        if (cell_row == ROW_W'(r) && cell_col == COL_W'(c))
          alive_bit = act_alive[r * ALIEN_COLS + c];
      end
    end
  end

  sprite_rom u_alien_rom (
    .sprite_id (alien_id),
    .row       (loc_y[2:0]),
    .col       (loc_x[3:0]),
    .pixel     (alien_bit)
  );

  assign alien_hit = in_span(gdx, 11'(GRID_W)) && in_span(gdy, 11'(GRID_H)) &&
                     (loc_x < 11'(SPR_W)) && (loc_y < 11'(SPR_H)) &&
                     alive_bit && alien_bit;

  // ---------------------------------------------------------------------------
  // Priority mux and output register
  // ---------------------------------------------------------------------------
  logic [11:0] colour_next;

  always_comb begin
    colour_next = BLACK;
    if (pbul_hit)        colour_next = WHITE;
    else if (abul_hit)   colour_next = RED;
    else if (player_hit) colour_next = GREEN;
    else if (alien_hit)  colour_next = alien_colour;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pixel_data <= '0;
    else       pixel_data <= colour_next;
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: directed scenarios plus randomized traffic for
// sprite_renderer, checked against a behavioural scene model.
module tb_sprite_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_addr, v_addr;
  logic        frame_sync, upd_valid, upd_ready;
  logic [9:0]  upd_player_x, upd_grid_x, upd_grid_y;
  logic [39:0] upd_alive;
  logic [9:0]  upd_pbul_x, upd_pbul_y, upd_abul_x, upd_abul_y;
  logic        upd_pbul_en, upd_abul_en;
  logic [11:0] pixel_data;

  always #5 clk = ~clk;

  sprite_renderer #(
    .ALIEN_COLS (8),
    .ALIEN_ROWS (5),
    .CELL_W     (24),
    .CELL_H     (16),
    .PLAYER_Y   (440)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .h_addr       (h_addr),
    .v_addr       (v_addr),
    .frame_sync   (frame_sync),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_player_x (upd_player_x),
    .upd_grid_x   (upd_grid_x),
    .upd_grid_y   (upd_grid_y),
    .upd_alive    (upd_alive),
    .upd_pbul_x   (upd_pbul_x),
    .upd_pbul_y   (upd_pbul_y),
    .upd_abul_x   (upd_abul_x),
    .upd_abul_y   (upd_abul_y),
    .upd_pbul_en  (upd_pbul_en),
    .upd_abul_en  (upd_abul_en),
    .pixel_data   (pixel_data)
  );

  typedef struct {
    int          px, gx, gy;
    logic [39:0] alive;
    bit          pbe, abe;
    int          pbx, pby, abx, aby;
  } scene_t;

  scene_t act, pend, din;
  bit     full;
  int     fc;
  int     n_total = 0;
  int     n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bitmap(input int id, input int r);
    logic [15:0] a [8], b [8], p [8];
    a = '{16'h0810, 16'h0420, 16'h0FF0, 16'h1BD8, 16'h3FFC, 16'h2FF4, 16'h2814, 16'h0660};
    b = '{16'h0810, 16'h2424, 16'h2FF4, 16'h3BDC, 16'h3FFC, 16'h1FF8, 16'h0810, 16'h1008};
    p = '{16'h0180, 16'h03C0, 16'h03C0, 16'h3FFC, 16'h7FFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    if (id == 0) return a[r];
    if (id == 1) return b[r];
    return p[r];
  endfunction

  function automatic logic [11:0] row_col(input int r);
    logic [11:0] t [5];
    t = '{12'hF0F, 12'h0FF, 12'hFF0, 12'h08F, 12'hF80};
    return t[r % 5];
  endfunction

  function automatic logic [11:0] model_pixel(input int h, input int v);
    int dx, dy, c, r, lx, ly, fr;
    logic [15:0] bits;
    if (act.pbe && h >= act.pbx && h < act.pbx + 2 && v >= act.pby && v < act.pby + 6)
      return 12'hFFF;
    if (act.abe && h >= act.abx && h < act.abx + 2 && v >= act.aby && v < act.aby + 6)
      return 12'hF00;
    dx = h - act.px;
    dy = v - 440;
    if (dx >= 0 && dx < 16 && dy >= 0 && dy < 8) begin
      bits = bitmap(2, dy);
      if (bits[15 - dx]) return 12'h0F0;
    end
    dx = h - act.gx;
    dy = v - act.gy;
    if (dx >= 0 && dy >= 0 && dx < 8 * 24 && dy < 5 * 16) begin
      c  = dx / 24;
      r  = dy / 16;
      lx = dx % 24;
      ly = dy % 16;
`ifdef SPRITE_ANIM_EN
      fr = (fc / 32) % 2;
`else
      fr = 0;
`endif
      if (lx < 16 && ly < 8 && act.alive[r * 8 + c]) begin
        bits = bitmap(fr, ly);
        if (bits[15 - lx]) return row_col(r);
      end
    end
    return 12'h000;
  endfunction

  task automatic model_reset();
    act = '{px: 312, gx: 0, gy: 0, alive: '0, pbe: 0, abe: 0,
            pbx: 0, pby: 0, abx: 0, aby: 0};
    pend = act;
    full = 0;
    fc   = 0;
  endtask

  task automatic drive_upd(input scene_t s);
    din          = s;
    upd_player_x = 10'(s.px);
    upd_grid_x   = 10'(s.gx);
    upd_grid_y   = 10'(s.gy);
    upd_alive    = s.alive;
    upd_pbul_en  = s.pbe;
    upd_pbul_x   = 10'(s.pbx);
    upd_pbul_y   = 10'(s.pby);
    upd_abul_en  = s.abe;
    upd_abul_x   = 10'(s.abx);
    upd_abul_y   = 10'(s.aby);
  endtask

  function automatic scene_t mk(input int px, input int gx, input int gy, input logic [39:0] alive,
                                input bit pbe, input int pbx, input int pby);
    scene_t s;
    s = '{px: px, gx: gx, gy: gy, alive: alive, pbe: pbe, abe: 0,
          pbx: pbx, pby: pby, abx: 0, aby: 0};
    return s;
  endfunction

  task automatic set_xy(input int h, input int v);
    h_addr = 10'(h);
    v_addr = 10'(v);
  endtask

  // Called just after a falling edge with inputs applied; returns after the
  // next falling edge with the registered pixel checked.
  task automatic cycle(input string tag);
    logic [11:0] exp_pix;
    bit was_full;
    check({tag, "_ready"}, 32'(upd_ready), full ? 32'd0 : 32'd1);
    exp_pix  = model_pixel(int'(h_addr), int'(v_addr));
    was_full = full;
    if (frame_sync) fc++;
    if (frame_sync && was_full) begin
      act  = pend;
      full = 0;
    end
    if (upd_valid && !was_full) begin
      pend = din;
      full = 1;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pix"}, 32'(pixel_data), 32'(exp_pix));
  endtask

  task automatic do_reset();
    upd_valid  = 0;
    frame_sync = 0;
    #2 reset = 1;
    #1;
    check("rst_pix", 32'(pixel_data), 32'h000);
    check("rst_ready", 32'(upd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    check("rst_release_pix", 32'(pixel_data), 32'h000);
  endtask

  initial begin
    int hits, wraps, early;
    logic [63:0] r64;
    scene_t u;

    reset = 1;
    frame_sync = 0;
    upd_valid = 0;
    drive_upd(mk(0, 0, 0, '0, 0, 0, 0));
    set_xy(0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("init_pix", 32'(pixel_data), 32'h000);
    check("init_ready", 32'(upd_ready), 32'd1);
    reset = 0;

    // Idle pixel after reset
    set_xy(100, 100);
    cycle("r032");
    check("r032_black", 32'(pixel_data), 32'h000);
    check("r032_rdy", 32'(upd_ready), 32'd1);

    // Player bullet appears only after frame_sync
    drive_upd(mk(200, 0, 0, '0, 1, 201, 300));
    upd_valid = 1;
    cycle("r033_load");
    upd_valid = 0;
    set_xy(201, 300);
    cycle("r033_pre");
    check("r033_pre_black", 32'(pixel_data), 32'h000);
    frame_sync = 1;
    cycle("r033_fs");
    frame_sync = 0;
    cycle("r033_post");
    check("r033_white", 32'(pixel_data), 32'hFFF);

    // Back-to-back updates: second held until frame_sync
    set_xy(10, 10);
    drive_upd(mk(400, 0, 0, '0, 0, 0, 0));
    upd_valid = 1;
    cycle("r034_u1");
    drive_upd(mk(500, 0, 0, '0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      cycle("r034_hold");
      check("r034_held", 32'(upd_ready), 32'd0);
    end
    frame_sync = 1;
    cycle("r034_fs");
    frame_sync = 0;
    check("r034_rise", 32'(upd_ready), 32'd1);
    cycle("r034_u2");
    upd_valid = 0;
    frame_sync = 1;
    cycle("r034_commit");
    frame_sync = 0;

    // Transfer coincident with frame_sync waits one more frame
    set_xy(55, 445);
    drive_upd(mk(50, 0, 0, '0, 0, 0, 0));
    upd_valid = 1;
    frame_sync = 1;
    cycle("r035_co");
    upd_valid = 0;
    frame_sync = 0;
    cycle("r035_wait");
    check("r035_unchanged", 32'(pixel_data), 32'h000);
    check("r035_pending", 32'(upd_ready), 32'd0);
    frame_sync = 1;
    cycle("r035_fs");
    frame_sync = 0;
    cycle("r035_after");
    check("r035_green", 32'(pixel_data), 32'h0F0);

    // Grid at the right edge clips without wrapping
    drive_upd(mk(0, 630, 100, '1, 0, 0, 0));
    upd_valid = 1;
    cycle("r036_load");
    upd_valid = 0;
    frame_sync = 1;
    cycle("r036_fs");
    frame_sync = 0;
    hits = 0; wraps = 0; early = 0;
    for (int h = 0; h < 640; h++) begin
      set_xy(h, 104);
      cycle("r036_scan");
      if (pixel_data != 12'h000) begin
        hits++;
        if (h < 16) wraps++;
        if (h < 630) early++;
      end
    end
    check("r036_hits", 32'(hits > 0), 32'd1);
    check("r036_wrap", 32'(wraps), 32'd0);
    check("r036_left", 32'(early), 32'd0);

    // Mid-frame reset with a full slot discards the pending update
    drive_upd(mk(100, 100, 100, '1, 1, 120, 120));
    upd_valid = 1;
    cycle("r027_load");
    upd_valid = 0;
    set_xy(121, 121);
    do_reset();
    frame_sync = 1;
    cycle("r027_fs");
    frame_sync = 0;
    cycle("r027_after");
    check("r027_discard", 32'(pixel_data), 32'h000);

    // Animation frame switch after 32 frame_sync pulses (one already above)
    drive_upd(mk(312, 100, 100, '1, 0, 0, 0));
    upd_valid = 1;
    cycle("r037_load");
    upd_valid = 0;
    frame_sync = 1;
    cycle("r037_fs");
    frame_sync = 0;
    set_xy(102, 101);
    cycle("r037_a");
    check("r037_frame_a", 32'(pixel_data), 32'h000);
    for (int i = 0; i < 29; i++) begin
      frame_sync = 1;
      cycle("r037_pulse");
      frame_sync = 0;
      cycle("r037_gap");
    end
    check("r037_still_a", 32'(pixel_data), 32'h000);
    frame_sync = 1;
    cycle("r037_last");
    frame_sync = 0;
    cycle("r037_b");
`ifdef SPRITE_ANIM_EN
    check("r037_frame_b", 32'(pixel_data), 32'hF0F);
`else
    check("r037_frame_b", 32'(pixel_data), 32'h000);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel, h, v;
      r64 = {$urandom, $urandom};
      u.px = $urandom % 640; u.gx = $urandom % 640; u.gy = $urandom % 480;
      u.alive = r64[39:0];
      u.pbe = $urandom % 2; u.pbx = $urandom % 640; u.pby = $urandom % 480;
      u.abe = $urandom % 2; u.abx = $urandom % 640; u.aby = $urandom % 480;
      drive_upd(u);
      upd_valid  = ($urandom % 6) == 0;
      frame_sync = ($urandom % 40) == 0;
      sel = $urandom % 5;
      case (sel)
        0: begin h = $urandom % 640;               v = $urandom % 480;               end
        1: begin h = act.gx + $urandom % 200;      v = act.gy + $urandom % 90;       end
        2: begin h = act.px - 2 + $urandom % 20;   v = 436 + $urandom % 14;          end
        3: begin h = act.pbx - 1 + $urandom % 4;   v = act.pby - 1 + $urandom % 8;   end
        default: begin h = act.abx - 1 + $urandom % 4; v = act.aby - 1 + $urandom % 8; end
      endcase
      if (h < 0) h = 0;
      if (v < 0) v = 0;
      set_xy(h % 640, v % 480);
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
